// File: rtl/fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl
//   IF-stage sequencer for the RV32I 5-stage pipeline. Owns the PC register,
//   drives the IF/ID stall/flush and ID/EX bubble controls, and arbitrates EX
//   branch redirects, ID load-use hazards and instruction-memory wait states.
//   Also keeps a saturating count of lost fetch cycles.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   RUN        | normal fetch; pc advances by 4 on every accepted word
//   REDIR_PEND | redirect taken while imem was busy; pc held until memory
//              | answers, then pc is loaded with the pending target
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   imem_ready            instruction word for current pc valid this cycle
//   id_rs1, id_rs2        source registers of the instruction in ID
//   idex_mem_read, idex_rd  load flag / destination of the instruction in EX
//   branch_taken, branch_target  redirect request from EX
//   pc                    registered fetch address
//   imem_req              fetch request (high whenever out of reset)
//   if_id_stall/flush     IF/ID register hold / NOP insert
//   id_ex_bubble          turn ID/EX into a bubble
//   bubble_count          saturating count of stall|flush cycles
// -----------------------------------------------------------------------------
module fetch_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      pc,
    output logic             imem_req,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] pend_pc;
    logic [31:0] target;
    logic        load_use;

    // Redirects are always word aligned.
    assign target   = branch_target & 32'hFFFF_FFFC;
    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    assign imem_req = reset_n;

    always_comb begin
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (reset_n) begin
            if (state == REDIR_PEND) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                // Any word returned this cycle is dropped and refetched.
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (!imem_ready) begin
                if_id_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            pc           <= RESET_PC;
            pend_pc      <= 32'h0000_0000;
            bubble_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            pc <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= REDIR_PEND;
                        end
                    end else if (!load_use && imem_ready) begin
                        pc <= pc + 32'd4;
                    end
                end
                REDIR_PEND: begin
                    if (branch_taken) begin
                        pend_pc <= target;
                    end
                    if (imem_ready) begin
                        pc    <= branch_taken ? target : pend_pc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if ((if_id_stall || if_id_flush) && !(&bubble_count)) begin
                bubble_count <= bubble_count + CNT_ONE;
            end
        end
    end

endmodule
